// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin arbiter that lends one 3-bit interval counter
// to two requesters. The owner gets a one-cycle done pulse when its interval
// has elapsed. Every output comes from a flop.
module counter_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] req,
  input  logic [2:0] len0,
  input  logic [2:0] len1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic [2:0] count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic [2:0] count_q, count_d;
  logic [2:0] lenR_q, lenR_d;
  logic       last_q, last_d;
  logic       busy_q, busy_d;
  logic       winner;
  logic       grantedIdx;

  // The owner's index is the position of the set bit in the one-hot grant.
  assign grantedIdx = gnt_q[1];

  // Next-state logic. It picks a winner in IDLE, counts ticks in RUN and
  // pulses done in DONE. Abort is tested first so that it wins over completion.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    count_d = count_q;
    lenR_d  = lenR_q;
    last_d  = last_q;
    winner  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d   = 2'b00;
        count_d = 3'd0;
        if (req != 2'b00) begin
          if (req == 2'b11) winner = ~last_q;
          else              winner = req[1];
          gnt_d   = winner ? 2'b10 : 2'b01;
          lenR_d  = winner ? len1 : len0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!req[grantedIdx]) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          count_d = 3'd0;
          last_d  = grantedIdx;
        end else if (lenR_q == 3'd0) begin
          state_d = DONE;
          done_d  = gnt_q;
        end else if (tick && (count_q == (lenR_q - 3'd1))) begin
          state_d = DONE;
          done_d  = gnt_q;
        end else if (tick) begin
          count_d = count_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        count_d = 3'd0;
        last_d  = grantedIdx;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        count_d = 3'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers. Reset is synchronous. The round-robin
  // pointer comes out of reset favouring requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      count_q <= 3'd0;
      lenR_q  <= 3'd0;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      count_q <= count_d;
      lenR_q  <= lenR_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Testbench for counter_scheduler. A job-level reference model tracks the
// owner, the job length and the ticks consumed, and it predicts the outputs.
module tb_counter_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [1:0] req;
  logic [2:0] len0, len1;
  logic [1:0] gnt, done;
  logic       busy;
  logic [2:0] count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model. Phase 0 is idle, 1 is counting and 2 is completion.
  int mPhase, mOwner, mLast, mLen, mTicks;

  counter_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .req(req),
    .len0(len0), .len1(len1),
    .gnt(gnt), .done(done), .busy(busy), .count(count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Advance the model by one clock edge, using the inputs seen at that edge
  task automatic modelStep();
    if (reset) begin
      mPhase = 0; mOwner = 0; mLast = 1; mLen = 0; mTicks = 0;
    end else begin
      case (mPhase)
        0: if (req != 2'b00) begin
             if (req == 2'b11) mOwner = 1 - mLast;
             else              mOwner = req[1] ? 1 : 0;
             mLen   = (mOwner == 1) ? int'(len1) : int'(len0);
             mTicks = 0;
             mPhase = 1;
           end
        1: if (!req[mOwner]) begin
             mLast  = mOwner;
             mPhase = 0;
           end else if (mLen == 0) begin
             mPhase = 2;
           end else if (tick) begin
             mTicks = mTicks + 1;
             if (mTicks == mLen) mPhase = 2;
           end
        default: begin
          mLast  = mOwner;
          mPhase = 0;
        end
      endcase
    end
  endtask

  // Predicted outputs packed as {gnt, done, busy, count}
  function automatic logic [7:0] expOut();
    logic [1:0] g, d;
    logic       b;
    int         c;
    g = (mPhase != 0) ? ((mOwner == 1) ? 2'b10 : 2'b01) : 2'b00;
    d = (mPhase == 2) ? g : 2'b00;
    b = (mPhase != 0);
    if (mPhase == 0 || mLen == 0) c = 0;
    else if (mTicks >= mLen)      c = mLen - 1;
    else                          c = mTicks;
    return {g, d, b, 3'(c)};
  endfunction

  // One clock cycle: the edge, the model update, then settle before sampling
  task automatic step();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1; req = 2'b00; tick = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b11; tick = 1'b1; len0 = 3'd5; len1 = 3'd2;
    step();
    vectors++;
    if ({gnt, done, busy, count} !== 8'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %b want %b", {gnt, done, busy, count}, 8'b0);
    end
    reset = 1'b0; req = 2'b00;
  endtask

  task automatic test_single_job();
    logic [7:0] want [5] = '{8'b01_00_1_000, 8'b01_00_1_001, 8'b01_00_1_010,
                             8'b01_01_1_010, 8'b00_00_0_000};
    doReset();
    req = 2'b01; len0 = 3'd3; tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 4) req = 2'b00;
      vectors++;
      if ({gnt, done, busy, count} !== want[i] || want[i] !== expOut()) begin
        miscompares++;
        $display("[TB] FAIL single_job cyc%0d: got %b want %b model %b",
                 i, {gnt, done, busy, count}, want[i], expOut());
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] grants [$];
    logic [1:0] prevGnt;
    doReset();
    req = 2'b11; len0 = 3'd1; len1 = 3'd1; tick = 1'b1;
    prevGnt = 2'b00;
    for (int i = 0; i < 15; i++) begin
      step();
      vectors++;
      if ({gnt, done, busy, count} !== expOut()) begin
        miscompares++;
        $display("[TB] FAIL contention cyc%0d: got %b want %b", i, {gnt, done, busy, count}, expOut());
      end
      if (prevGnt == 2'b00 && gnt != 2'b00) grants.push_back(gnt);
      prevGnt = gnt;
    end
    req = 2'b00;
    vectors++;
    if (grants.size() != 5) begin
      miscompares++;
      $display("[TB] FAIL contention_grant_count: got %0d want 5", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      vectors++;
      if (grants[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("[TB] FAIL contention_order grant%0d: got %b want %b",
                 i, grants[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
  endtask

  task automatic test_max_len();
    int  ticksInRun = 0;
    int  maxCount = 0;
    bit  seenDone = 0;
    doReset();
    req = 2'b10; len1 = 3'd7; len0 = 3'd2; tick = 1'b1;
    for (int i = 0; i < 40 && !seenDone; i++) begin
      if (gnt == 2'b10 && done == 2'b00 && tick) ticksInRun++;
      step();
      tick = ~tick;
      len1 = 3'($urandom_range(0, 7));
      vectors++;
      if ({gnt, done, busy, count} !== expOut()) begin
        miscompares++;
        $display("[TB] FAIL max_len cyc%0d: got %b want %b", i, {gnt, done, busy, count}, expOut());
      end
      if (int'(count) > maxCount) maxCount = int'(count);
      if (done == 2'b10) seenDone = 1;
    end
    req = 2'b00;
    vectors++;
    if (!seenDone || ticksInRun != 7) begin
      miscompares++;
      $display("[TB] FAIL max_len_ticks: got %0d ticks (done seen %0d) want 7", ticksInRun, seenDone);
    end
    vectors++;
    if (maxCount != 6) begin
      miscompares++;
      $display("[TB] FAIL max_len_peak: got %0d want 6", maxCount);
    end
    step();
  endtask

  task automatic test_zero_len();
    logic [7:0] want [3] = '{8'b01_00_1_000, 8'b01_01_1_000, 8'b00_00_0_000};
    doReset();
    req = 2'b01; len0 = 3'd0; tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 1) req = 2'b00;
      vectors++;
      if ({gnt, done, busy, count} !== want[i] || want[i] !== expOut()) begin
        miscompares++;
        $display("[TB] FAIL zero_len cyc%0d: got %b want %b model %b",
                 i, {gnt, done, busy, count}, want[i], expOut());
      end
    end
  endtask

  task automatic test_abort();
    doReset();
    req = 2'b01; len0 = 3'd5; tick = 1'b1;
    step(); step(); step();
    vectors++;
    if (count !== 3'd2 || gnt !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL abort_setup: got gnt %b count %0d want 01 2", gnt, count);
    end
    req = 2'b00;
    step();
    vectors++;
    if ({gnt, done, busy, count} !== 8'b0 || expOut() !== 8'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_drop: got %b want %b", {gnt, done, busy, count}, 8'b0);
    end
    req = 2'b11;
    step();
    vectors++;
    if (gnt !== 2'b10 || expOut() !== 8'b10_00_1_000) begin
      miscompares++;
      $display("[TB] FAIL abort_rr: got gnt %b want 10", gnt);
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_reset_midrun();
    doReset();
    req = 2'b10; len1 = 3'd6; tick = 1'b1;
    step(); step(); step();
    reset = 1'b1;
    step();
    vectors++;
    if ({gnt, done, busy, count} !== 8'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_midrun: got %b want %b", {gnt, done, busy, count}, 8'b0);
    end
    reset = 1'b0; req = 2'b00;
    step();
    vectors++;
    if (done !== 2'b00 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_midrun_nodone: got done %b busy %b want 00 0", done, busy);
    end
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      tick  = ($urandom_range(0, 2) != 0);
      len0  = 3'($urandom_range(0, 7));
      len1  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
      step();
      vectors++;
      if ({gnt, done, busy, count} !== expOut()) begin
        miscompares++;
        $display("[TB] FAIL random cyc%0d: got %b want %b", i, {gnt, done, busy, count}, expOut());
      end
    end
    reset = 1'b0;
  endtask

  // Run the scenarios in order, then print the summary
  initial begin
    reset = 1'b1; tick = 1'b0; req = 2'b00; len0 = 3'd0; len1 = 3'd0;
    mPhase = 0; mOwner = 0; mLast = 1; mLen = 0; mTicks = 0;
    test_reset();
    test_single_job();
    test_contention();
    test_max_len();
    test_zero_len();
    test_abort();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Sequencer and round-robin arbiter that shares one 3-bit mod-7 interval counter between two requesters. Each requester asks for an interval of 0..7 counted ticks. The block grants the counter to one requester at a time, runs the count, and returns a one-cycle completion pulse. It sits between the control FSMs that need timed waits and the shared 3-bit counting datapath.

## Interface
- No parameters; all widths fixed (2 requesters, 3-bit count).
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- tick  in  1  count enable; the counter advances only on cycles with tick=1.
- req  in  2  request per requester; must stay high until that requester's done, or the job aborts.
- len0  in  3  interval length for requester 0; sampled at grant.
- len1  in  3  interval length for requester 1; sampled at grant.
- gnt  out  2  one-hot grant; 00 when idle.
- done  out  2  one-cycle completion pulse to the granted requester.
- busy  out  1  high whenever state is not IDLE.
- count  out  3  current counter value.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: gnt=00, done=00, busy=0, count=0. The round-robin pointer resets to last=1, so requester 0 wins the first contention.
- IDLE:
  - req=00: stay in IDLE.
  - Exactly one request set: grant it.
  - req=11: grant the requester that is not `last`.
  - On grant: latch the winner's len into len_r, set count=0, set gnt, go to RUN.
- RUN:
  - Abort: if req of the granted requester is 0, go to IDLE. Pulse no done. Set last=granted.
  - Else if len_r=0: go to DONE unconditionally. This is a zero-tick job and tick is ignored.
  - Else if tick=1 and count=len_r-1: go to DONE. count holds its value.
  - Else if tick=1: count=count+1 (3-bit, never exceeds 6).
  - tick=0: hold.
- DONE: assert done for the granted bit only, keep gnt, set last=granted, go to IDLE.
- Leaving DONE or aborting clears gnt and count to 0 in IDLE.
- Abort has priority over completion when both apply in the same RUN cycle.
- len0/len1 changes after grant have no effect on the running job.
- The counter value range is 0..6. len_r=7 therefore counts through 0..6, which is seven ticks.
- Reset in any state returns to IDLE on that edge. An in-flight job is discarded with no done.

## Timing
- Grant latency: req seen high in IDLE at edge N means gnt and busy are high after edge N, and count=0.
- Tick counting: a job of len L≥1 consumes exactly L cycles with tick=1 in RUN. Those ticks move count 0→L-1.
- done pulse timing: done is high for exactly one cycle, the cycle after the final tick edge (the DONE state).
- Job duration with tick held high: gnt is high for L+1 cycles (L RUN cycles plus 1 DONE cycle). len=0 gives 2 cycles (1 RUN plus 1 DONE).
- Minimum gap: at least one IDLE cycle with gnt=00 separates consecutive grants, even under continuous requests.
- Output registering: all outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset then single job: reset, then req=01, len0=3, tick=1 held.
  - gnt=01 the cycle after req is seen high in IDLE.
  - count steps 0,1,2; done=01 for exactly one cycle (the DONE cycle); gnt then returns to 00.
- Contention and fairness: req=11 held continuously, len0=len1=1.
  - Grants alternate 01, 10, 01, …, starting with 01.
  - Each grant is followed by one done pulse and one IDLE cycle before the next grant.
- Tick gating and max length: len1=7, req=10, tick toggling 1,0 every cycle.
  - count reaches 6 and never 7.
  - done=10 arrives after exactly 7 tick-high cycles.
- Zero length: len0=0, req=01, tick=0 throughout.
  - Sequence is gnt=01 for 2 cycles, done=01 on the second, then IDLE.
- Abort and reset mid-run:
  - Drop req[0] at count=2 of a len0=5 job: next cycle gnt=00, no done pulse, and req=11 is then granted to requester 1.
  - Separately, assert reset mid-RUN: all outputs are 0 on the next cycle and no done pulse occurs.
